// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: 2-flop synchronizer, sample-tick divider, mid-bit sampling FSM.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_ctrl #(
  parameter int unsigned DIV        = 54,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 vld_rx,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 busy
);

  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] OS_LAST   = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                state_q, state_d;
  logic                  rxd_meta_q, rxs_q;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [BIDX_W-1:0]     bidx_q, bidx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  vld_q, vld_d;
  logic                  frm_q, frm_d;
  logic                  tick;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  par_err_q, par_err_d;
`endif

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    vld_d     = 1'b0;
    frm_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tick && !rxs_q) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == HALF_LAST) begin
            scnt_d  = '0;
            bidx_d  = '0;
            state_d = rxs_q ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt_q == OS_LAST) begin
            scnt_d          = '0;
            shift_d[bidx_q] = rxs_q;
            if (bidx_q == BIDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bidx_d = bidx_q + BIDX_W'(1);
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt_q == OS_LAST) begin
            scnt_d  = '0;
            par_d   = rxs_q;
            state_d = STOP;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (scnt_q == OS_LAST) begin
            scnt_d = '0;
            // A low stop bit parks in WAIT_HIGH so a held break cannot look like a new start bit.
            if (!rxs_q) begin
              frm_d   = 1'b1;
              state_d = WAIT_HIGH;
            end else begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shift_q, par_q}) begin
                par_err_d = 1'b1;
              end else begin
                rx_data_d = shift_q;
                vld_d     = 1'b1;
              end
`else
              rx_data_d = shift_q;
              vld_d     = 1'b1;
`endif
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      div_q      <= '0;
      state_q    <= IDLE;
      scnt_q     <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      vld_q      <= 1'b0;
      frm_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
      div_q      <= div_d;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      vld_q      <= vld_d;
      frm_q      <= frm_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rx_data = rx_data_q;
  assign vld_rx  = vld_q;
  assign frm_err = frm_q;
  assign busy    = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule
